// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch stage
package if_pkg;
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} fetch_state_t;
  localparam logic [31:0] NOP_INST = 32'h0;
  localparam logic [31:0] INST_BYTES = 32'd4;
endpackage

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: req/ack instruction fetch feeding IF/ID, with stall hold and redirect squash
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc4,
  output logic [31:0] if_inst,
  output logic        if_valid
);
  localparam logic [31:0] PC0 = RESET_PC & ~32'd3;
  fetch_state_t state, state_nxt;
  logic [31:0] pc, req_addr, buf_inst, pc_inc, tgt;
  logic        advance, abandon, capture;
  assign pc_inc  = pc + INST_BYTES;
  assign tgt     = redirect_pc & ~32'd3;
  assign advance = !stall && ((state == FETCH && imem_ack) || state == HOLD);
  assign abandon = redirect && state == FETCH && !imem_ack;
  assign capture = !redirect && stall && state == FETCH && imem_ack;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) state <= FETCH;
    else state <= state_nxt;
  // a request already on the bus must complete before the target can be fetched
  always_comb
    state_nxt = state == FETCH ? (abandon ? DRAIN : capture ? HOLD : FETCH)
              : state == HOLD  ? ((redirect || !stall) ? FETCH : HOLD)
              : (imem_ack ? FETCH : DRAIN);
  always_comb begin
    imem_req  = state != HOLD;
    imem_addr = state == DRAIN ? req_addr : pc;
    if_valid  = !redirect && (state == HOLD || (state == FETCH && imem_ack));
    if_inst   = !if_valid ? NOP_INST : state == HOLD ? buf_inst : imem_rdata;
    if_pc4    = pc_inc;
  end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      pc       <= PC0;
      req_addr <= 32'h0;
      buf_inst <= 32'h0;
    end else begin
      pc <= redirect ? tgt : advance ? pc_inc : pc;
      if (abandon) req_addr <= pc;
      if (capture) buf_inst <= imem_rdata;
    end
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

- Instruction-fetch stage that drives the IF/ID pipeline register.
- Produces the next instruction and its PC+4, and honours the hazard unit's stall by holding its output stable.
- Handles branch/jump redirects from ID, squashing the wrong-path slot.
- Fetches through a req/ack instruction-memory port that may insert wait states.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] ignored.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- stall  in  1  hazard-unit stall; the same signal that freezes IF/ID.
- redirect  in  1  ID-stage taken branch/jump, valid for one cycle.
- redirect_pc  in  32  target for redirect; bits [1:0] forced to 0.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  request address; word aligned.
- imem_ack  in  1  memory completion; may be asserted in the cycle imem_req first rises.
- imem_rdata  in  32  instruction word; valid only with imem_ack.
- if_pc4  out  32  PC+4 of the presented instruction; wraps mod 2^32.
- if_inst  out  32  presented instruction; 32'h0 (NOP) when no valid instruction.
- if_valid  out  1  if_inst/if_pc4 carry a real instruction.

## Operation
Registers:
- pc: 32 bits, next fetch address.
- req_addr: 32 bits, address of an abandoned outstanding request.
- buf_inst: 32 bits.
- state ∈ {FETCH, HOLD, DRAIN}.

States:
- FETCH:
  - imem_req=1, imem_addr=pc.
  - When ack=1: if_valid=1, if_inst=imem_rdata, if_pc4=pc+4 (combinational pass-through).
  - When ack=0: if_valid=0, if_inst=0, if_pc4=pc+4.
- HOLD:
  - imem_req=0.
  - if_valid=1, if_inst=buf_inst, if_pc4=pc+4.
- DRAIN:
  - imem_req=1, imem_addr=req_addr.
  - if_valid=0, if_inst=0, if_pc4=pc+4.
  - Returning data is discarded.

Squash: when redirect=1, force if_valid=0 and if_inst=0 in that cycle, in every state. IF/ID therefore captures a NOP for the wrong-path slot.

Transitions at each rising edge, in priority order:
1. redirect=1:
   - FETCH with ack=1: pc<=redirect_pc, stay FETCH.
   - FETCH with ack=0: req_addr<=pc, pc<=redirect_pc, go DRAIN.
   - HOLD: pc<=redirect_pc, go FETCH; buffer dropped.
   - DRAIN with ack=0: pc<=redirect_pc, stay DRAIN.
   - DRAIN with ack=1: pc<=redirect_pc, go FETCH.
   - Redirect overrides stall.
2. FETCH, ack=1, stall=0: pc<=pc+4, stay FETCH.
3. FETCH, ack=1, stall=1: buf_inst<=imem_rdata, go HOLD.
4. FETCH, ack=0: hold; imem_addr stays stable until ack.
5. HOLD, stall=0: pc<=pc+4, go FETCH.
6. HOLD, stall=1: hold.
7. DRAIN, ack=1: go FETCH (pc already holds the target).

Memory rule: once imem_req=1 with a given address, that address and req stay unchanged until ack. The block never abandons a transaction.

Reset (clrn=0), effective immediately:
- state=FETCH, pc=RESET_PC, req_addr=0, buf_inst=0.
- Outputs: if_valid=0 unless ack, if_inst=0, if_pc4=RESET_PC+4.
- Memory shares clrn and ignores req during reset.
- Reset mid-transaction or mid-DRAIN discards all state.

## Timing
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle; redirect-to-target-presented latency is 1 cycle.
- N wait states: instruction presented in the ack cycle, captured at that edge if stall=0.
- Stall: outputs stay bit-identical for every stalled cycle. Memory is not re-accessed while in HOLD.
- Redirect during an outstanding miss costs the remaining miss cycles plus the full target fetch.
- pc+4 from 32'hFFFF_FFFC wraps to 32'h0.

## Structure
- Package if_pkg:
  - state enum fetch_state_t {FETCH, HOLD, DRAIN};
  - NOP_INST=32'h0;
  - INST_BYTES=4.
- Single module, no sub-module: the state register, pc/req_addr/buf registers and output muxes are one small datapath.

## Test plan
- Reset release, zero-wait memory, stall=0 → imem_addr 0,4,8 on consecutive cycles; if_pc4 4,8,12; if_valid=1 each cycle.
- ack delayed 2 cycles for addr 0x10 → imem_addr held at 0x10 for 3 cycles; if_inst=0 and if_valid=0 until the ack cycle; then if_inst=rdata, if_pc4=0x14.
- stall=1 for 3 cycles arriving in an ack cycle with rdata=0x8C220004 → HOLD; if_inst stays 0x8C220004 and imem_req=0 all 3 cycles. After stall drops, the next fetch is pc+4.
- redirect=1, redirect_pc=0x200 while in FETCH with ack=1 → if_inst=0 that cycle; the next cycle imem_addr=0x200.
- redirect to 0x300 while a request to 0x40 is outstanding → imem_addr stays 0x40 until ack; that data never appears (if_valid=0); the next request is to 0x300.
- redirect while in HOLD with stall=1 → buffer dropped; imem_addr=target the next cycle. Separately, clrn pulsed mid-DRAIN → pc=RESET_PC and state FETCH immediately.
